// File: rtl/led_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_scan_pkg
//  Purpose  : Shared types and constants for the LED matrix scan receiver.
//             Holds the frame-assembly state enum, the row/column widths and
//             the active-low 7-segment codes {A..G} for digits 0..9.
//  Revision : 1.0 - initial release
// ============================================================================
package led_scan_pkg;

    localparam int ROW_W = 3;
    localparam int COL_W = 8;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } scan_state_t;

    // Segment order {A,B,C,D,E,F,G}, 0 = segment lit
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational active-low 7-segment pattern to BCD decoder.
//  Ports    : seg   in  7  segment pattern {A..G}, 0 = lit
//             valid out 1  pattern matched a known digit
//             bcd   out 4  decoded digit (4'hF when not valid)
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import led_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'hF;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scan_rx
//  Purpose  : Samples a multiplexed 8x8 RGB matrix scan (row select COMM,
//             active-low DATA_R/G/B, EN), rebuilds complete frames in a
//             shadow buffer and commits them to a host-readable buffer.
//  Ports    : CLK, clear (sync active-high reset)
//             COMM/EN/DATA_R/G/B  scan inputs (asynchronous to CLK)
//             d7_1/COMM_CLK       7-seg score inputs (SEG7_DECODE_EN only)
//             rd_row -> rd_R/G/B  registered read of committed frame
//             frame_valid, frame_cnt, scan_err, stale, digit0/1, digit_err
//  Config   : `define SEG7_DECODE_EN to build the 7-segment score decoder;
//             otherwise digit0/digit1/digit_err are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scan_rx
    import led_scan_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic [ROW_W-1:0] COMM,
    input  logic             EN,
    input  logic [COL_W-1:0] DATA_R,
    input  logic [COL_W-1:0] DATA_G,
    input  logic [COL_W-1:0] DATA_B,
    input  logic [6:0]       d7_1,
    input  logic [1:0]       COMM_CLK,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_R,
    output logic [COL_W-1:0] rd_G,
    output logic [COL_W-1:0] rd_B,
    output logic             frame_valid,
    output logic [7:0]       frame_cnt,
    output logic             scan_err,
    output logic             stale,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic             digit_err
);

    localparam logic [7:0]       C_SETTLE  = 8'(SETTLE);
    localparam logic [7:0]       C_SET_M1  = 8'(SETTLE - 1);
    localparam logic [15:0]      C_TIMEOUT = 16'(TIMEOUT);
    localparam logic [ROW_W-1:0] C_LAST    = ROW_W'(7);

    // ---------------- input synchronizers ----------------
    logic [ROW_W-1:0] r_comm_m, r_comm_s;
    logic             r_en_m, r_en_s;
    logic [COL_W-1:0] r_dr_m, r_dr_s, r_dg_m, r_dg_s, r_db_m, r_db_s;

    always_ff @(posedge CLK) begin
        if (clear) begin
            r_comm_m <= '0; r_comm_s <= '0;
            r_en_m   <= 1'b0; r_en_s <= 1'b0;
            r_dr_m   <= '0; r_dr_s <= '0;
            r_dg_m   <= '0; r_dg_s <= '0;
            r_db_m   <= '0; r_db_s <= '0;
        end else begin
            r_comm_m <= COMM;   r_comm_s <= r_comm_m;
            r_en_m   <= EN;     r_en_s   <= r_en_m;
            r_dr_m   <= DATA_R; r_dr_s   <= r_dr_m;
            r_dg_m   <= DATA_G; r_dg_s   <= r_dg_m;
            r_db_m   <= DATA_B; r_db_s   <= r_db_m;
        end
    end

    // ---------------- dwell tracking ----------------
    logic [ROW_W-1:0] r_comm_prev;
    logic [7:0]       r_settle;
    logic             w_steady;
    logic             w_capture;

    assign w_steady  = r_en_s && (r_comm_s == r_comm_prev);
    // Fires only on the transition to SETTLE; the counter then saturates,
    // so each dwell yields exactly one capture.
    assign w_capture = w_steady && (r_settle == C_SET_M1);

    always_ff @(posedge CLK) begin
        if (clear) begin
            r_comm_prev <= '0;
            r_settle    <= '0;
        end else begin
            r_comm_prev <= r_comm_s;
            if (!w_steady)
                r_settle <= '0;
            else if (r_settle != C_SETTLE)
                r_settle <= r_settle + 8'd1;
        end
    end

    // ---------------- frame assembly FSM ----------------
    scan_state_t      r_state, w_state_nx;
    logic [ROW_W-1:0] r_expected, w_expected_nx;
    logic             w_shadow_we, w_commit, w_set_err;

    always_ff @(posedge CLK) begin
        if (clear) begin
            r_state    <= HUNT;
            r_expected <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_expected <= w_expected_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_expected_nx = r_expected;
        w_shadow_we   = 1'b0;
        w_commit      = 1'b0;
        w_set_err     = 1'b0;
        if (w_capture) begin
            case (r_state)
                HUNT: begin
                    if (r_comm_s == '0) begin
                        w_shadow_we   = 1'b1;
                        w_expected_nx = ROW_W'(1);
                        w_state_nx    = COLLECT;
                    end
                end
                COLLECT: begin
                    if (r_comm_s == r_expected) begin
                        w_shadow_we = 1'b1;
                        if (r_comm_s == C_LAST) begin
                            w_commit   = 1'b1;
                            w_state_nx = HUNT;
                        end else begin
                            w_expected_nx = r_expected + ROW_W'(1);
                        end
                    end else begin
                        w_set_err = 1'b1;
                        // An out-of-order row 0 restarts a frame immediately
                        if (r_comm_s == '0) begin
                            w_shadow_we   = 1'b1;
                            w_expected_nx = ROW_W'(1);
                            w_state_nx    = COLLECT;
                        end else begin
                            w_state_nx = HUNT;
                        end
                    end
                end
                default: w_state_nx = HUNT;
            endcase
        end
    end

    // ---------------- shadow / committed buffers ----------------
    logic [COL_W-1:0] r_sh_r [8], r_sh_g [8], r_sh_b [8];
    logic [COL_W-1:0] r_cm_r [8], r_cm_g [8], r_cm_b [8];

    always_ff @(posedge CLK) begin
        if (clear) begin
            for (int i = 0; i < 8; i++) begin
                r_sh_r[i] <= '0; r_sh_g[i] <= '0; r_sh_b[i] <= '0;
                r_cm_r[i] <= '0; r_cm_g[i] <= '0; r_cm_b[i] <= '0;
            end
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            scan_err    <= 1'b0;
            rd_R        <= '0;
            rd_G        <= '0;
            rd_B        <= '0;
        end else begin
            if (w_shadow_we) begin
                r_sh_r[r_comm_s] <= ~r_dr_s;
                r_sh_g[r_comm_s] <= ~r_dg_s;
                r_sh_b[r_comm_s] <= ~r_db_s;
            end
            // Row 7 lands in the shadow on this same edge, so take it
            // straight from the capture data rather than the shadow.
            if (w_commit) begin
                for (int i = 0; i < 7; i++) begin
                    r_cm_r[i] <= r_sh_r[i];
                    r_cm_g[i] <= r_sh_g[i];
                    r_cm_b[i] <= r_sh_b[i];
                end
                r_cm_r[7] <= ~r_dr_s;
                r_cm_g[7] <= ~r_dg_s;
                r_cm_b[7] <= ~r_db_s;
            end
            frame_valid <= w_commit;
            frame_cnt   <= frame_cnt + {7'd0, w_commit};
            scan_err    <= scan_err | w_set_err;
            rd_R        <= r_cm_r[rd_row];
            rd_G        <= r_cm_g[rd_row];
            rd_B        <= r_cm_b[rd_row];
        end
    end

    // ---------------- stale detection ----------------
    logic [15:0] r_stale_cnt;

    always_ff @(posedge CLK) begin
        if (clear)
            r_stale_cnt <= '0;
        else if (w_capture)
            r_stale_cnt <= '0;
        else if (r_stale_cnt != C_TIMEOUT)
            r_stale_cnt <= r_stale_cnt + 16'd1;
    end

    assign stale = (r_stale_cnt == C_TIMEOUT);

    // ---------------- optional 7-segment score decoder ----------------
`ifdef SEG7_DECODE_EN
    logic [6:0] r_seg_m, r_seg_s;
    logic [1:0] r_dsel_m, r_dsel_s;
    logic [8:0] r_sd_prev;
    logic [7:0] r_seg_settle;
    logic       w_seg_steady, w_seg_cap;
    logic       w_dec_valid;
    logic [3:0] w_dec_bcd;

    seg7_decode u_seg7_decode (
        .seg   (r_seg_s),
        .valid (w_dec_valid),
        .bcd   (w_dec_bcd)
    );

    assign w_seg_steady = ({r_dsel_s, r_seg_s} == r_sd_prev);
    assign w_seg_cap    = w_seg_steady && (r_seg_settle == C_SET_M1);

    always_ff @(posedge CLK) begin
        if (clear) begin
            r_seg_m      <= '0; r_seg_s  <= '0;
            r_dsel_m     <= '0; r_dsel_s <= '0;
            r_sd_prev    <= '0;
            r_seg_settle <= '0;
            digit0       <= '0;
            digit1       <= '0;
            digit_err    <= 1'b0;
        end else begin
            r_seg_m   <= d7_1;     r_seg_s  <= r_seg_m;
            r_dsel_m  <= COMM_CLK; r_dsel_s <= r_dsel_m;
            r_sd_prev <= {r_dsel_s, r_seg_s};
            if (!w_seg_steady)
                r_seg_settle <= '0;
            else if (r_seg_settle != C_SETTLE)
                r_seg_settle <= r_seg_settle + 8'd1;
            if (w_seg_cap && (r_dsel_s == 2'b10 || r_dsel_s == 2'b01)) begin
                if (r_dsel_s == 2'b10)
                    digit0 <= w_dec_bcd;
                else
                    digit1 <= w_dec_bcd;
                digit_err <= digit_err | ~w_dec_valid;
            end
        end
    end
`else
    logic w_unused_seg;
    assign w_unused_seg = ^{d7_1, COMM_CLK};
    assign digit0       = '0;
    assign digit1       = '0;
    assign digit_err    = 1'b0;
`endif

endmodule
`default_nettype wire
